// File: rtl/sy_pkg.sv
// sy_pkg: shared TileLink-UL opcode encodings and bus constants
package sy_pkg;
   localparam int SRC_W = 4;
   typedef enum logic [2:0] {
      TL_PUT_FULL    = 3'd0,
      TL_PUT_PARTIAL = 3'd1,
      TL_GET         = 3'd4
   } tl_a_op_e;
   typedef enum logic [2:0] {
      TL_ACCESS_ACK      = 3'd0,
      TL_ACCESS_ACK_DATA = 3'd1
   } tl_d_op_e;
endpackage

// File: rtl/reg2tl_be.sv
// reg2tl_be: single-outstanding register access to TileLink-UL initiator with timeout
module reg2tl_be
   import sy_pkg::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int SOURCE_ID      = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic                    ready_o,
   output logic                    done_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o,
   output logic                    a_valid_o,
   input  logic                    a_ready_i,
   output logic [2:0]              a_opcode_o,
   output logic [2:0]              a_size_o,
   output logic [SRC_W-1:0]        a_source_o,
   output logic [ADDR_WIDTH-1:0]   a_address_o,
   output logic [DATA_WIDTH/8-1:0] a_mask_o,
   output logic [DATA_WIDTH-1:0]   a_data_o,
   input  logic                    d_valid_i,
   output logic                    d_ready_o,
   input  logic [2:0]              d_opcode_i,
   input  logic                    d_denied_i,
   input  logic                    d_corrupt_i,
   input  logic [DATA_WIDTH-1:0]   d_data_i
);
   localparam int BW  = DATA_WIDTH / 8;
   localparam int LSB = $clog2(BW);
   localparam int CW  = $clog2(TIMEOUT_CYCLES);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          expired;
   logic          is_read;
   logic          resp_err;
   assign ready_o   = state == IDLE;
   assign a_valid_o = state == REQ;
   assign d_ready_o = state == RESP || state == DRAIN;
   assign expired   = cnt == CW'(TIMEOUT_CYCLES - 1);
   assign is_read   = a_opcode_o == TL_GET;
   assign resp_err  = d_denied_i | (is_read & d_corrupt_i) |
                      (d_opcode_i != (is_read ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK));
   // request/response sequencing; timeout has priority over a late A handshake in REQ,
   // while a D handshake on the expiry cycle completes normally
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         rdata_o     <= '0;
         a_opcode_o  <= '0;
         a_size_o    <= '0;
         a_source_o  <= '0;
         a_address_o <= '0;
         a_mask_o    <= '0;
         a_data_o    <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (en_i) begin
               if (we_i && be_i == '0) begin
                  done_o <= 1'b1;
                  err_o  <= 1'b0;
               end else begin
                  state       <= REQ;
                  cnt         <= '0;
                  a_opcode_o  <= we_i ? (&be_i ? TL_PUT_FULL : TL_PUT_PARTIAL) : TL_GET;
                  a_size_o    <= 3'(LSB);
                  a_source_o  <= SRC_W'(SOURCE_ID);
                  a_address_o <= addr_i & ~ADDR_WIDTH'(BW - 1);
                  a_mask_o    <= we_i ? be_i : '1;
                  a_data_o    <= wdata_i;
               end
            end
            REQ: if (expired) begin
               done_o <= 1'b1;
               err_o  <= 1'b1;
               state  <= IDLE;
            end else begin
               cnt <= cnt + 1'b1;
               if (a_ready_i) state <= RESP;
            end
            RESP: if (d_valid_i) begin
               done_o <= 1'b1;
               err_o  <= resp_err;
               if (is_read) rdata_o <= d_data_i;
               state  <= IDLE;
            end else if (expired) begin
               done_o <= 1'b1;
               err_o  <= 1'b1;
               cnt    <= '0;
               state  <= DRAIN;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: if (d_valid_i || expired) state <= IDLE;
                     else cnt <= cnt + 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_reg2tl_be.sv
// tb_reg2tl_be: scoreboard bench for reg2tl_be with a reactive TileLink slave
module tb_reg2tl_be;
   import sy_pkg::*;
   localparam int TO = 16;
   logic        clk_i = 1'b0;
   logic        rst_i, en_i, we_i;
   logic [63:0] addr_i, wdata_i;
   logic [7:0]  be_i;
   logic        ready_o, done_o, err_o;
   logic [63:0] rdata_o;
   logic        a_valid_o, a_ready_i;
   logic [2:0]  a_opcode_o, a_size_o;
   logic [SRC_W-1:0] a_source_o;
   logic [63:0] a_address_o, a_data_o;
   logic [7:0]  a_mask_o;
   logic        d_valid_i, d_ready_o, d_denied_i, d_corrupt_i;
   logic [2:0]  d_opcode_i;
   logic [63:0] d_data_i;

   always #5 clk_i = ~clk_i;

   reg2tl_be #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .SOURCE_ID(0), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .be_i(be_i), .ready_o(ready_o), .done_o(done_o),
      .rdata_o(rdata_o), .err_o(err_o), .a_valid_o(a_valid_o), .a_ready_i(a_ready_i),
      .a_opcode_o(a_opcode_o), .a_size_o(a_size_o), .a_source_o(a_source_o),
      .a_address_o(a_address_o), .a_mask_o(a_mask_o), .a_data_o(a_data_o),
      .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i),
      .d_denied_i(d_denied_i), .d_corrupt_i(d_corrupt_i), .d_data_i(d_data_i)
   );

   typedef struct { logic [2:0] op; logic [63:0] addr; logic [7:0] mask; logic [63:0] data; logic wr; } a_exp_t;
   typedef struct { logic err; logic [63:0] rdata; } d_exp_t;
   a_exp_t a_q[$];
   d_exp_t d_q[$];
   int n_vec = 0, n_err = 0;
   int a_hs_n = 0, d_hs_n = 0, late_n = 0;
   logic [63:0] last_rdata = '0;
   int a_stall = 0;
   logic resp_en = 1'b1, cfg_den = 1'b0, cfg_cor = 1'b0;
   logic [2:0] cfg_op = 3'd1;
   logic [63:0] cfg_data = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic exp_a(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic wr);
      a_q.push_back('{op, addr, mask, data, wr});
   endtask

   task automatic exp_d(input logic err);
      d_q.push_back('{err, last_rdata});
   endtask

   task automatic xfer(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [7:0] be, output int lat);
      en_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
      step();
      en_i = 1'b0;
      lat = 1;
      while (!done_o && lat < 64) begin
         step();
         lat++;
      end
      if (!done_o) chk("done_seen", 64'd0, 64'd1);
   endtask

   // monitor: A/D handshakes and completions against the scoreboard
   initial begin
      a_exp_t ea;
      d_exp_t ed;
      logic prev_wait;
      logic [138:0] prev_a;
      prev_wait = 1'b0;
      prev_a = '0;
      forever begin
         @(negedge clk_i);
         if (a_valid_o && prev_wait)
            chk("a_stable", 64'({a_opcode_o, a_address_o, a_mask_o, a_data_o} == prev_a), 64'd1);
         prev_wait = a_valid_o && !a_ready_i;
         prev_a = {a_opcode_o, a_address_o, a_mask_o, a_data_o};
         if (a_valid_o && a_ready_i) begin
            a_hs_n++;
            if (a_q.size() == 0) chk("a_unexpected", 64'd1, 64'd0);
            else begin
               ea = a_q.pop_front();
               chk("a_opcode", 64'(a_opcode_o), 64'(ea.op));
               chk("a_address", a_address_o, ea.addr);
               chk("a_mask", 64'(a_mask_o), 64'(ea.mask));
               chk("a_size", 64'(a_size_o), 64'd3);
               chk("a_source", 64'(a_source_o), 64'd0);
               if (ea.wr) chk("a_data", a_data_o, ea.data);
            end
         end
         if (d_valid_i && d_ready_o) d_hs_n++;
         if (done_o) begin
            if (d_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
            else begin
               ed = d_q.pop_front();
               chk("err", 64'(err_o), 64'(ed.err));
               chk("rdata", rdata_o, ed.rdata);
            end
         end
      end
   end

   // slave: accepts A after a_stall cycles, answers next cycle, optional late beat
   initial begin
      int a_wait, a_seen, d_seen, l_seen;
      logic d_pend;
      a_wait = 0; a_seen = 0; d_seen = 0; l_seen = 0; d_pend = 1'b0;
      a_ready_i = 1'b0; d_valid_i = 1'b0; d_opcode_i = '0;
      d_denied_i = 1'b0; d_corrupt_i = 1'b0; d_data_i = '0;
      forever begin
         @(posedge clk_i);
         #2;
         if (d_hs_n != d_seen) begin
            d_seen = d_hs_n;
            d_valid_i = 1'b0;
         end
         if (a_hs_n != a_seen) begin
            a_seen = a_hs_n;
            d_pend = resp_en;
         end
         if (d_pend || late_n != l_seen) begin
            l_seen = late_n;
            d_pend = 1'b0;
            d_valid_i = 1'b1;
            d_opcode_i = cfg_op;
            d_denied_i = cfg_den;
            d_corrupt_i = cfg_cor;
            d_data_i = cfg_data;
         end
         if (a_valid_o) begin
            a_ready_i = a_wait >= a_stall;
            a_wait++;
         end else begin
            a_ready_i = 1'b0;
            a_wait = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int lat, n0;
      rst_i = 1'b1; en_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
      step();
      step();
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_a_valid", 64'(a_valid_o), 64'd0);
      chk("rst_d_ready", 64'(d_ready_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_rdata", rdata_o, 64'd0);
      chk("rst_a_fields", 64'({a_opcode_o, a_size_o, a_mask_o} | 14'(a_address_o != 0)), 64'd0);
      rst_i = 1'b0;
      step();
      cfg_op = 3'd1; cfg_data = 64'hDEAD_BEEF_0123_4567; last_rdata = cfg_data;
      exp_a(3'd4, 64'h8000_0010, 8'hFF, 64'd0, 1'b0); exp_d(1'b0);
      xfer(1'b0, 64'h8000_0010, 64'd0, 8'hFF, lat);
      chk("rd_latency", 64'(lat), 64'd3);
      chk("ready_on_done", 64'(ready_o), 64'd1);
      cfg_op = 3'd0;
      exp_a(3'd0, 64'h1000, 8'hFF, 64'h1122_3344_5566_7788, 1'b1); exp_d(1'b0);
      xfer(1'b1, 64'h1004, 64'h1122_3344_5566_7788, 8'hFF, lat);
      chk("wr_full_latency", 64'(lat), 64'd3);
      exp_a(3'd1, 64'h1000, 8'h0F, 64'h99AA_BBCC_DDEE_FF00, 1'b1); exp_d(1'b0);
      xfer(1'b1, 64'h1004, 64'h99AA_BBCC_DDEE_FF00, 8'h0F, lat);
      chk("wr_part_latency", 64'(lat), 64'd3);
      a_stall = 5; n0 = a_hs_n;
      exp_a(3'd1, 64'h2000, 8'h3C, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1); exp_d(1'b0);
      xfer(1'b1, 64'h2007, 64'h0F0F_0F0F_0F0F_0F0F, 8'h3C, lat);
      chk("stall_latency", 64'(lat), 64'd8);
      chk("stall_single_req", 64'(a_hs_n - n0), 64'd1);
      a_stall = 0;
      cfg_op = 3'd1; cfg_den = 1'b1; cfg_data = 64'hA5A5_A5A5_A5A5_A5A5; last_rdata = cfg_data;
      exp_a(3'd4, 64'h3000, 8'hFF, 64'd0, 1'b0); exp_d(1'b1);
      xfer(1'b0, 64'h3000, 64'd0, 8'h00, lat);
      cfg_den = 1'b0; cfg_op = 3'd0; cfg_data = 64'h5A5A_5A5A_5A5A_5A5A; last_rdata = cfg_data;
      exp_a(3'd4, 64'h3000, 8'hFF, 64'd0, 1'b0); exp_d(1'b1);
      xfer(1'b0, 64'h3003, 64'd0, 8'h00, lat);
      cfg_op = 3'd1; cfg_cor = 1'b1; cfg_data = 64'h0000_1111_2222_3333; last_rdata = cfg_data;
      exp_a(3'd4, 64'h3100, 8'hFF, 64'd0, 1'b0); exp_d(1'b1);
      xfer(1'b0, 64'h3100, 64'd0, 8'hFF, lat);
      cfg_op = 3'd0;
      exp_a(3'd1, 64'h3200, 8'h01, 64'h55, 1'b1); exp_d(1'b0);
      xfer(1'b1, 64'h3200, 64'h55, 8'h01, lat);
      cfg_cor = 1'b0; cfg_op = 3'd1; cfg_data = 64'hFFFF_0000_FFFF_0000;
      resp_en = 1'b0;
      exp_a(3'd4, 64'h4000, 8'hFF, 64'd0, 1'b0); exp_d(1'b1);
      xfer(1'b0, 64'h4000, 64'd0, 8'hFF, lat);
      chk("resp_timeout_latency", 64'(lat), 64'(TO + 1));
      chk("drain_ready", 64'(ready_o), 64'd0);
      chk("drain_d_ready", 64'(d_ready_o), 64'd1);
      n0 = d_hs_n;
      late_n++;
      for (int i = 0; i < 6 && !ready_o; i++) step();
      chk("drain_exit", 64'(ready_o), 64'd1);
      chk("late_beat_consumed", 64'(d_hs_n - n0), 64'd1);
      resp_en = 1'b1; a_stall = 1000; n0 = a_hs_n;
      exp_d(1'b1);
      xfer(1'b0, 64'h5000, 64'd0, 8'hFF, lat);
      chk("req_timeout_latency", 64'(lat), 64'(TO + 1));
      chk("req_timeout_a_valid", 64'(a_valid_o), 64'd0);
      chk("req_timeout_no_hs", 64'(a_hs_n - n0), 64'd0);
      a_stall = 0; n0 = a_hs_n;
      exp_d(1'b0);
      xfer(1'b1, 64'h6000, 64'h1234, 8'h00, lat);
      chk("be0_latency", 64'(lat), 64'd1);
      step();
      chk("be0_a_valid", 64'(a_valid_o), 64'd0);
      chk("be0_no_hs", 64'(a_hs_n - n0), 64'd0);
      resp_en = 1'b0;
      exp_a(3'd4, 64'h7000, 8'hFF, 64'd0, 1'b0);
      en_i = 1'b1; we_i = 1'b0; addr_i = 64'h7000; be_i = 8'hFF;
      step();
      en_i = 1'b0;
      step();
      chk("in_resp", 64'(d_ready_o), 64'd1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("rst_mid_ready", 64'(ready_o), 64'd1);
      chk("rst_mid_d_ready", 64'(d_ready_o), 64'd0);
      repeat (3) step();
      resp_en = 1'b1; last_rdata = 64'h0BAD_CAFE_0000_0001; cfg_data = last_rdata; cfg_op = 3'd1;
      exp_a(3'd4, 64'h8000, 8'hFF, 64'd0, 1'b0); exp_d(1'b0);
      xfer(1'b0, 64'h8000, 64'd0, 8'hFF, lat);
      chk("recover_latency", 64'(lat), 64'd3);
      step();
      chk("a_queue_empty", 64'(a_q.size()), 64'd0);
      chk("d_queue_empty", 64'(d_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/reg2tl_be.md
# reg2tl_be

Register-to-TileLink-UL initiator: accepts one single-beat register-style access (address, write data, byte enables) from a local requester, issues it as a TileLink A-channel request, waits for the D-channel response, and returns read data and status. It is the initiator-side counterpart of `TL2Reg_be`, which terminates TL requests into a register port. It sits in front of any peripheral that reaches system memory or other slaves over `TL_BUS`. One access is in flight at a time; a timeout guards against a dead slave.

## Interface
- `ADDR_WIDTH`, 64, address width.
- `DATA_WIDTH`, 64, data width; power of two, ≥ 8.
- `SOURCE_ID`, 0, constant `a_source` value; width `SRC_W` = 4.
- `TIMEOUT_CYCLES`, 1024, cycles allowed from first `a_valid_o` to D handshake; ≥ 2.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: request strobe, sampled when `ready_o`=1.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in ADDR_WIDTH: byte address.
- `wdata_i` in DATA_WIDTH: write data.
- `be_i` in DATA_WIDTH/8: byte enables.
- `ready_o` out 1: idle, can accept a request.
- `done_o` out 1: one-cycle completion pulse.
- `rdata_o` out DATA_WIDTH: read data, valid with `done_o`, held until next `done_o`.
- `err_o` out 1: error status, valid with `done_o`.
- `a_valid_o`, `a_ready_i` out/in 1: A-channel handshake.
- `a_opcode_o` out 3; `a_size_o` out 3; `a_source_o` out SRC_W; `a_address_o` out ADDR_WIDTH; `a_mask_o` out DATA_WIDTH/8; `a_data_o` out DATA_WIDTH.
- `d_valid_i`, `d_ready_o` in/out 1: D-channel handshake.
- `d_opcode_i` in 3; `d_denied_i` in 1; `d_corrupt_i` in 1; `d_data_i` in DATA_WIDTH.

## Operation
- States: `IDLE`, `REQ`, `RESP`, `DRAIN`.
- `IDLE`: `ready_o`=1. `en_i`=1 registers the request → `REQ`. A write with `be_i`=0 issues nothing: `done_o` pulses next cycle with `err_o`=0, and the state stays `IDLE`.
- Opcode: a read issues Get (4) with `a_mask_o` all ones. A write with `be_i` all ones issues PutFullData (0); otherwise PutPartialData (1).
- `a_size_o` = log2(DATA_WIDTH/8).
- `a_address_o` = `addr_i` with its low log2(DATA_WIDTH/8) bits forced to 0.
- `a_data_o` = `wdata_i`, `a_mask_o` = `be_i` for writes.
- `REQ`: `a_valid_o`=1 and all A fields stable until `a_valid_o` & `a_ready_i`, then → `RESP`.
- `RESP`: `d_ready_o`=1. On `d_valid_i`, capture `rdata_o` (reads only), pulse `done_o`, then → `IDLE`.
- `err_o` = `d_denied_i` | `d_corrupt_i` (reads only) | opcode mismatch. The expected opcode is AccessAckData (1) for a read, AccessAck (0) for a write.
- Timeout: the counter starts at 0 on entry to `REQ` and runs through `REQ`/`RESP`. On reaching `TIMEOUT_CYCLES`−1 without a D handshake:
  - `done_o`=1 with `err_o`=1, `rdata_o` unchanged.
  - From `REQ`, drop `a_valid_o` and → `IDLE`.
  - From `RESP` → `DRAIN`.
- `DRAIN`: `d_ready_o`=1, `ready_o`=0. Exits to `IDLE` after one D beat is consumed (discarded) or after `TIMEOUT_CYCLES` further cycles.
- `en_i` outside `IDLE` is ignored. The requester must hold nothing after acceptance.

## Timing
- Reset (synchronous): state `IDLE`; `ready_o`=1; `a_valid_o`, `d_ready_o`, `done_o`, `err_o`=0; `rdata_o`=0; all A fields 0; counter 0. Reset mid-transaction abandons it with no `done_o`.
- Accept at cycle t → `a_valid_o` high at t+1.
- D handshake at cycle n → `done_o` at n+1, and `ready_o` also at n+1.
- Minimum read latency: accept t; A handshake t+1; D handshake t+2; `done_o` t+3.
- `d_valid_i` during `REQ` is ignored: `d_ready_o`=0.
- A D handshake on the same cycle the counter expires counts as a normal completion, not a timeout.
- Back-to-back: a new `en_i` is accepted on the `done_o` cycle.

## Structure
- Shared package `sy_pkg`: `tl_a_op_e` (Get, PutFullData, PutPartialData) and `tl_d_op_e` (AccessAck, AccessAckData) enums, and the `SRC_W` constant.
- State enum is local.
- No sub-module needed; the timeout counter is inline.

## Test plan
- Read 0x8000_0010: slave `a_ready_i` immediate; D in the next cycle with opcode 1, data 0xDEAD_BEEF_0123_4567. Expect Get, size 3, mask 0xFF, `done_o` at t+3, matching `rdata_o`, `err_o`=0.
- Write be=0xFF then be=0x0F to 0x1004. Expect PutFullData then PutPartialData; address 0x1000; mask 0xFF/0x0F; AccessAck; `err_o`=0.
- `a_ready_i` stalled 5 cycles. Expect `a_valid_o` and all A fields stable throughout; a single request is issued.
- Read answered with `d_denied_i`=1, and separately with opcode 0. Expect `err_o`=1 in both cases.
- `TIMEOUT_CYCLES`=16, no D response. Expect `done_o`/`err_o`=1 at cycle 16 after the first `a_valid_o`; a late D beat is consumed in `DRAIN`; `ready_o` returns high afterwards.
- Write with be=0. Expect no A traffic and `done_o` next cycle. Separately, `rst_i` asserted in `RESP`: expect `IDLE` and no `done_o`.
